// File: rtl/poly_mul_seq_if.sv
// Public-coefficient stream into the polynomial multiplier sequencer.
// The source drives a_valid/a_data; the sequencer answers with a_ready.
interface poly_mul_seq_if #(
    parameter int QW = 13
) ();
    logic          a_valid;
    logic [QW-1:0] a_data;
    logic          a_ready;

    modport master (output a_valid, output a_data, input a_ready);
    modport slave  (input a_valid, input a_data, output a_ready);
endinterface

// File: rtl/poly_mul_seq.sv
// Sequencer / operand stage in front of the 256-lane MAC array.
// Computes a(x)*s(x) mod (x^256+1, 2^13): each streamed a_i is staged with its
// x2..x5 multiples, the MAC array returns acc + a_i*s lane-wise, and the secret
// is multiplied by x (negacyclic rotate) after every applied coefficient.
module poly_mul_seq #(
    parameter int N  = 256,
    parameter int QW = 13,
    parameter int SW = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    poly_mul_seq_if.slave          a_if,
    input  logic                   start_i,
    input  logic [N-1:0][SW-1:0]   secret_in_i,
    output logic [N-1:0][QW-1:0]   mac_acc_o,
    output logic [N-1:0][SW-1:0]   mac_secret_o,
    output logic [QW-1:0]          mac_a_coeff_o,
    output logic [QW-1:0]          mac_a_mul_2_o,
    output logic [QW-1:0]          mac_a_mul_3_o,
    output logic [QW-1:0]          mac_a_mul_4_o,
    output logic [QW-1:0]          mac_a_mul_5_o,
    input  logic [N-1:0][QW-1:0]   mac_result_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N-1:0][QW-1:0]   poly_out_o,
    output logic                   result_valid_o
);

    localparam int             CW    = $clog2(N) + 1;
    localparam logic [CW-1:0]  N_CNT = CW'(N);
    localparam logic [CW-1:0]  LAST  = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q;
    logic [N-1:0][QW-1:0]   acc_q;
    logic [N-1:0][SW-1:0]   sec_q;
    logic [N-1:0][SW-1:0]   sec_d;
    logic [QW-1:0]          a_q;
    logic [QW-1:0]          mul2_q, mul3_q, mul4_q, mul5_q;
    logic [QW-1:0]          mul2_d, mul3_d, mul4_d, mul5_d;
    logic                   stg_v_q;
    logic [CW-1:0]          acc_cnt_q;
    logic [CW-1:0]          app_cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   result_valid_q;
    logic [N-1:0][QW-1:0]   poly_out_q;
    logic                   a_rdy;
    logic                   accept;

    // Accept beats only in RUN and only until all N coefficients are in.
    assign a_rdy       = (state_q == S_RUN) && (acc_cnt_q < N_CNT);
    assign a_if.a_ready = a_rdy;
    assign accept      = a_rdy && a_if.a_valid;

    // Shift-add multiples of the incoming coefficient, truncated to QW bits.
    always_comb begin
        mul2_d = a_if.a_data << 1;
        mul3_d = a_if.a_data + (a_if.a_data << 1);
        mul4_d = a_if.a_data << 2;
        mul5_d = a_if.a_data + (a_if.a_data << 2);
    end

    // Secret times x: shift lanes up, wrap lane N-1 into lane 0 negated.
    // A zero magnitude keeps its sign bit so no -0 encoding is created.
    always_comb begin
        sec_d = '0;
        for (int j = 1; j < N; j++) begin
            sec_d[j] = sec_q[j-1];
        end
        sec_d[0] = {sec_q[N-1][SW-1] ^ (|sec_q[N-1][SW-2:0]), sec_q[N-1][SW-2:0]};
    end

    // Control FSM together with the operand stage (stage 1) and the
    // accumulate/rotate stage (stage 2); both stages advance every RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            sec_q          <= '0;
            a_q            <= '0;
            mul2_q         <= '0;
            mul3_q         <= '0;
            mul4_q         <= '0;
            mul5_q         <= '0;
            stg_v_q        <= 1'b0;
            acc_cnt_q      <= '0;
            app_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            poly_out_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        sec_q          <= secret_in_i;
                        acc_q          <= '0;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_cnt_q <= '0;
                    app_cnt_q <= '0;
                    stg_v_q   <= 1'b0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    // stage 1: register the beat and its multiples
                    if (accept) begin
                        a_q       <= a_if.a_data;
                        mul2_q    <= mul2_d;
                        mul3_q    <= mul3_d;
                        mul4_q    <= mul4_d;
                        mul5_q    <= mul5_d;
                        stg_v_q   <= 1'b1;
                        acc_cnt_q <= acc_cnt_q + 1'b1;
                    end else begin
                        stg_v_q   <= 1'b0;
                    end
                    // stage 2: take the MAC array's sum and advance the secret
                    if (stg_v_q) begin
                        acc_q     <= mac_result_i;
                        sec_q     <= sec_d;
                        app_cnt_q <= app_cnt_q + 1'b1;
                        if (app_cnt_q == LAST) begin
                            // final sum is the product; publish it as it lands
                            poly_out_q     <= mac_result_i;
                            result_valid_q <= 1'b1;
                            done_q         <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mac_acc_o      = acc_q;
    assign mac_secret_o   = sec_q;
    assign mac_a_coeff_o  = a_q;
    assign mac_a_mul_2_o  = mul2_q;
    assign mac_a_mul_3_o  = mul3_q;
    assign mac_a_mul_4_o  = mul4_q;
    assign mac_a_mul_5_o  = mul5_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign poly_out_o     = poly_out_q;
    assign result_valid_o = result_valid_q;

endmodule
